// File: rtl/mpc_vec_pkg.sv
// Shared types and constants for the solver vector stream reader.
// The optional max-abs tracker in the top is enabled by MPC_VREAD_MAXABS_EN.
package mpc_vec_pkg;

  localparam int VEC_DW    = 21;
  localparam int VEC_DEPTH = 6;
  localparam int VEC_AW    = 3;

  typedef logic signed [VEC_DW-1:0] vec_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vec_state_t;

  // Saturation limits of the signed fixed-point entry format.
  localparam vec_word_t VEC_MAXPOS = {1'b0, {(VEC_DW-1){1'b1}}};
  localparam vec_word_t VEC_MAXNEG = {1'b1, {(VEC_DW-1){1'b0}}};

endpackage

// File: rtl/mpc_vec_skid2.sv
// Two-entry FIFO used as the output skid buffer of the vector reader.
// The caller guarantees no push while full and no pop while empty.
module mpc_vec_skid2 #(
  parameter int W = 22
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/mpc_vec_stream_reader.sv
// Reads DEPTH entries from a single-port vector RAM (1-cycle latency) and
// streams them out on valid/ready under ap_start/ap_done control.
// Optional feature macro: MPC_VREAD_MAXABS_EN adds the maxabs output.
module mpc_vec_stream_reader
  import mpc_vec_pkg::*;
#(
  parameter int DEPTH = VEC_DEPTH,
  parameter int AW    = VEC_AW,
  parameter int DW    = VEC_DW
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  output logic [AW-1:0]        vec_address0,
  output logic                 vec_ce0,
  input  logic signed [DW-1:0] vec_q0,
  output logic signed [DW-1:0] m_data,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
`ifdef MPC_VREAD_MAXABS_EN
  ,
  output logic signed [DW-1:0] maxabs
`endif
);

  vec_state_t    state_q;
  logic [AW-1:0] rd_idx_q;
  logic          inflight_q;
  logic          cap_last_q;
  logic          done_q;
  logic          idle_q;

  logic [1:0]    occ;
  logic [DW:0]   skid_dout;
  logic          pop;
  logic [2:0]    pending_d;
  logic          issue;
  logic          last_issue;

  // Credit counts the entry in flight plus what stays buffered after this
  // cycle's pop, so the skid can never overflow yet still sustains 1/cycle.
  assign pop        = m_valid & m_ready;
  assign pending_d  = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == ST_READ) && (pending_d < 3'd2);
  assign last_issue = issue && (rd_idx_q == AW'(DEPTH-1));

  assign vec_ce0      = issue;
  assign vec_address0 = rd_idx_q;

  // Control FSM with registered handshake outputs and read bookkeeping.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
      cap_last_q <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      inflight_q <= issue;
      cap_last_q <= last_issue;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            state_q  <= ST_READ;
            rd_idx_q <= '0;
            idle_q   <= 1'b0;
          end
        end
        ST_READ: begin
          if (last_issue) state_q <= ST_DRAIN;
          else if (issue) rd_idx_q <= rd_idx_q + 1'b1;
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          rd_idx_q <= '0;
          idle_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mpc_vec_skid2 #(
    .W (DW+1)
  ) u_skid (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .push_i (inflight_q),
    .din_i  ({cap_last_q, vec_q0}),
    .pop_i  (pop),
    .dout_o (skid_dout),
    .occ_o  (occ)
  );

  assign m_valid  = (occ != 2'd0);
  assign m_data   = skid_dout[DW-1:0];
  assign m_last   = skid_dout[DW];
  assign ap_done  = done_q;
  assign ap_ready = done_q;
  assign ap_idle  = idle_q;

`ifdef MPC_VREAD_MAXABS_EN
  function automatic logic signed [DW-1:0] abs_sat(input logic signed [DW-1:0] v);
    if (v == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    else if (v < 0)                  return -v;
    else                             return v;
  endfunction

  logic signed [DW-1:0] maxabs_q;
  logic signed [DW-1:0] cap_abs;

  assign cap_abs = abs_sat(vec_q0);

  // Running max of |entry|, cleared when a new vector read starts.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                            maxabs_q <= '0;
    else if (state_q == ST_IDLE && ap_start)  maxabs_q <= '0;
    else if (inflight_q && cap_abs > maxabs_q) maxabs_q <= cap_abs;
  end

  assign maxabs = maxabs_q;
`endif

endmodule

// File: tb/tb_mpc_vec_stream_reader.sv
// Self-checking bench for mpc_vec_stream_reader: randomized and directed
// ready patterns against a queue-based reference of the RAM contents.
`timescale 1ns/1ps
module tb_mpc_vec_stream_reader;
  import mpc_vec_pkg::*;

  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int DW    = 21;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n;
  logic                 ap_start;
  logic                 ap_done, ap_idle, ap_ready;
  logic [AW-1:0]        vec_address0;
  logic                 vec_ce0;
  logic signed [DW-1:0] vec_q0 = '0;
  logic signed [DW-1:0] m_data;
  logic                 m_last, m_valid;
  logic                 m_ready;
`ifdef MPC_VREAD_MAXABS_EN
  logic signed [DW-1:0] maxabs;
`endif

  mpc_vec_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .vec_address0 (vec_address0),
    .vec_ce0      (vec_ce0),
    .vec_q0       (vec_q0),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready)
`ifdef MPC_VREAD_MAXABS_EN
    ,
    .maxabs       (maxabs)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // Single-port RAM model, one cycle read latency.
  vec_word_t ram [0:(1<<AW)-1];
  always @(posedge ap_clk) if (vec_ce0) vec_q0 <= ram[vec_address0];

  int total = 0;
  int bad   = 0;

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  vec_word_t got_data [$];
  bit        got_last [$];
  int        beat_cyc [$];
  int        done_cyc [$];
  bit        idle_trace [$];
  int        n_issue, n_accept, ce_viol, addr_bad, unstable, rdy_bad;
  int        snap_issue;
  logic      snap_valid;
  vec_word_t snap_data;
  vec_word_t maxabs_at_done;

  task automatic reset_stats();
    got_data.delete(); got_last.delete(); beat_cyc.delete();
    done_cyc.delete(); idle_trace.delete();
    n_issue = 0; n_accept = 0; ce_viol = 0; addr_bad = 0; unstable = 0; rdy_bad = 0;
    snap_issue = -1; snap_valid = 1'b0; snap_data = '0; maxabs_at_done = '0;
  endtask

  task automatic load_plan_ram();
    ram[0] = 5; ram[1] = -3; ram[2] = VEC_MAXPOS; ram[3] = VEC_MAXNEG;
    ram[4] = 0; ram[5] = 7; ram[6] = 0; ram[7] = 0;
  endtask

  // Drives n cycles and records observations. mode: 0 ready high,
  // 1 fixed toggle pattern, 2 ready low through cycle 20, 3 random ready.
  task automatic drive_cycles(input int n, input int mode, input int start_until);
    logic      prev_stall;
    vec_word_t prev_data;
    logic      prev_last;
    int        hs;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge ap_clk);
      ap_start = (c <= start_until);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[c % 6];
        2:       m_ready = (c > 20);
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      hs = (m_valid && m_ready) ? 1 : 0;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) unstable++;
      if (vec_ce0) begin
        if (n_issue - (n_accept + hs) >= 2) ce_viol++;
        if (vec_address0 !== AW'(n_issue % DEPTH)) addr_bad++;
        n_issue++;
      end
      if (hs == 1) begin
        got_data.push_back(m_data); got_last.push_back(m_last);
        beat_cyc.push_back(c); n_accept++;
      end
      if (ap_done === 1'b1) begin
        done_cyc.push_back(c);
`ifdef MPC_VREAD_MAXABS_EN
        maxabs_at_done = maxabs;
`endif
      end
      if (ap_ready !== ap_done) rdy_bad++;
      idle_trace.push_back(ap_idle);
      if (c == 20) begin snap_issue = n_issue; snap_valid = m_valid; snap_data = m_data; end
      prev_stall = m_valid && !m_ready; prev_data = m_data; prev_last = m_last;
    end
  endtask

  // Compares the captured beats with `reps` copies of the RAM vector.
  task automatic check_stream(input string tag, input int reps);
    total++;
    if (got_data.size() != DEPTH*reps) begin
      bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_data.size(), DEPTH*reps);
    end
    for (int i = 0; i < got_data.size() && i < DEPTH*reps; i++) begin
      total++;
      if (got_data[i] !== ram[i % DEPTH] || got_last[i] !== (i % DEPTH == DEPTH-1)) begin
        bad++;
        $display("FAIL %s_beat%0d got=%0d/%0b exp=%0d/%0b", tag, i, got_data[i], got_last[i],
                 ram[i % DEPTH], (i % DEPTH == DEPTH-1));
      end
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    #1;
    total++;
    if ({m_valid, m_data, m_last, vec_ce0, vec_address0, ap_done, ap_ready, ap_idle} !==
        {1'b0, {DW{1'b0}}, 1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%0d l=%b ce=%b a=%0d dn=%b rdy=%b idle=%b exp idle=1 rest 0",
               m_valid, m_data, m_last, vec_ce0, vec_address0, ap_done, ap_ready, ap_idle);
    end
    @(negedge ap_clk); ap_rst_n = 1'b1;
  endtask

  task automatic test_full_rate();
    load_plan_ram(); reset_stats();
    drive_cycles(14, 0, 0);
    check_stream("full", 1);
    total++;
    if (beat_cyc.size() != DEPTH || beat_cyc[0] != 3 || beat_cyc[DEPTH-1] != 8) begin
      bad++; $display("FAIL full_timing got first=%0d last=%0d exp 3/8",
                      beat_cyc.size() > 0 ? beat_cyc[0] : -1,
                      beat_cyc.size() > 0 ? beat_cyc[beat_cyc.size()-1] : -1);
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
      bad++; $display("FAIL full_done got n=%0d at=%0d exp n=1 at=9", done_cyc.size(),
                      done_cyc.size() > 0 ? done_cyc[0] : -1);
    end
    total++;
    if (rdy_bad != 0 || addr_bad != 0) begin
      bad++; $display("FAIL full_ready_addr got rdy_bad=%0d addr_bad=%0d exp 0/0", rdy_bad, addr_bad);
    end
  endtask

  task automatic test_toggle_ready();
    load_plan_ram(); reset_stats();
    drive_cycles(40, 1, 0);
    check_stream("toggle", 1);
    total++;
    if (ce_viol != 0) begin bad++; $display("FAIL toggle_credit got viol=%0d exp=0", ce_viol); end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL toggle_stable got=%0d exp=0", unstable); end
    total++;
    if (done_cyc.size() != 1 || beat_cyc.size() != DEPTH ||
        done_cyc[0] != beat_cyc[DEPTH-1] + 1) begin
      bad++; $display("FAIL toggle_done got n=%0d exp done one cycle after last beat", done_cyc.size());
    end
  endtask

  task automatic test_stall();
    load_plan_ram(); reset_stats();
    drive_cycles(34, 2, 0);
    total++;
    if (snap_issue != 2 || snap_valid !== 1'b1 || snap_data !== ram[0]) begin
      bad++; $display("FAIL stall_snapshot got issues=%0d valid=%b data=%0d exp 2/1/%0d",
                      snap_issue, snap_valid, snap_data, ram[0]);
    end
    check_stream("stall", 1);
    total++;
    if (done_cyc.size() != 1 || addr_bad != 0 || unstable != 0) begin
      bad++; $display("FAIL stall_done got n=%0d addr_bad=%0d unstable=%0d exp 1/0/0",
                      done_cyc.size(), addr_bad, unstable);
    end
  endtask

  task automatic test_back_to_back();
    int highs;
    load_plan_ram(); reset_stats();
    drive_cycles(26, 0, 10);
    check_stream("b2b", 2);
    total++;
    if (done_cyc.size() != 2 || done_cyc[0] != 9 || done_cyc[1] != 19) begin
      bad++; $display("FAIL b2b_done got n=%0d exp pulses at 9 and 19", done_cyc.size());
    end
    highs = 0;
    for (int c = 1; c <= 19; c++) if (idle_trace[c]) highs++;
    total++;
    if (highs != 1 || idle_trace[10] !== 1'b1 || idle_trace[0] !== 1'b1 || idle_trace[20] !== 1'b1) begin
      bad++; $display("FAIL b2b_idle got highs=%0d idle10=%b exp 1/1", highs, idle_trace[10]);
    end
  endtask

  task automatic test_async_abort();
    load_plan_ram(); reset_stats();
    drive_cycles(6, 0, 0);
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    total++;
    if (n_accept != 3) begin bad++; $display("FAIL abort_beats got=%0d exp=3", n_accept); end
    total++;
    if ({m_valid, m_data, m_last, vec_ce0, vec_address0, ap_done, ap_ready, ap_idle} !==
        {1'b0, {DW{1'b0}}, 1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL abort_reset_state got v=%b d=%0d ce=%b dn=%b idle=%b exp 0/0/0/0/1",
                      m_valid, m_data, vec_ce0, ap_done, ap_idle);
    end
    @(negedge ap_clk); ap_rst_n = 1'b1;
    reset_stats();
    drive_cycles(8, 0, -1);
    total++;
    if (done_cyc.size() != 0 || got_data.size() != 0 || n_issue != 0) begin
      bad++; $display("FAIL abort_quiet got done=%0d beats=%0d issues=%0d exp 0/0/0",
                      done_cyc.size(), got_data.size(), n_issue);
    end
    reset_stats();
    drive_cycles(14, 0, 0);
    check_stream("restart", 1);
    total++;
    if (addr_bad != 0 || done_cyc.size() != 1) begin
      bad++; $display("FAIL restart_addr got addr_bad=%0d done=%0d exp 0/1", addr_bad, done_cyc.size());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = vec_word_t'($urandom());
      reset_stats();
      drive_cycles(90, 3, 0);
      check_stream("rand", 1);
      total++;
      if (ce_viol != 0 || unstable != 0 || done_cyc.size() != 1 || rdy_bad != 0) begin
        bad++; $display("FAIL rand_ctrl got viol=%0d unstable=%0d done=%0d rdy_bad=%0d exp 0/0/1/0",
                        ce_viol, unstable, done_cyc.size(), rdy_bad);
      end
    end
  endtask

`ifdef MPC_VREAD_MAXABS_EN
  task automatic test_maxabs();
    load_plan_ram();
    ram[0] = VEC_MAXNEG; ram[1] = 3;
    reset_stats();
    drive_cycles(14, 0, 0);
    total++;
    if (done_cyc.size() != 1 || maxabs_at_done !== VEC_MAXPOS) begin
      bad++; $display("FAIL maxabs got=%0d exp=%0d", maxabs_at_done, VEC_MAXPOS);
    end
  endtask
`endif

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    test_reset();
    test_full_rate();
    test_toggle_ready();
    test_stall();
    test_back_to_back();
    test_async_abort();
    test_random();
`ifdef MPC_VREAD_MAXABS_EN
    test_maxabs();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
